gpio_irq: RTL and testbench



---
 rtl/gpio_irq.sv | 183 ++++++++++++++++++
 tb/tb_gpio_irq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq.sv
// gpio_irq: parametrised GPIO slave with per-pin direction, atomic set/clear,
// synchronised and glitch-filtered inputs, and rising/falling edge interrupts
// latched into W1C pending bits. Pads are tristated outside this block.
module gpio_irq #(
    parameter int GPIO_NUM = 16,
    parameter int FILT_LEN = 4,
    parameter int ADDR_LSB = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         data_i,
    output logic [31:0]         data_o,
    input  logic [GPIO_NUM-1:0] io_pin_i,
    output logic [GPIO_NUM-1:0] io_out,
    output logic [GPIO_NUM-1:0] io_oe,
    output logic                irq_o
);

    // Word offsets of the register map
    localparam logic [3:0] OFF_DIR  = 4'd0;
    localparam logic [3:0] OFF_OUT  = 4'd1;
    localparam logic [3:0] OFF_IN   = 4'd2;
    localparam logic [3:0] OFF_SET  = 4'd3;
    localparam logic [3:0] OFF_CLR  = 4'd4;
    localparam logic [3:0] OFF_IE   = 4'd5;
    localparam logic [3:0] OFF_RISE = 4'd6;
    localparam logic [3:0] OFF_FALL = 4'd7;
    localparam logic [3:0] OFF_PEND = 4'd8;

    // Filter counter only needs to reach FILT_LEN-1
    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((FILT_LEN > 0) ? (FILT_LEN - 1) : 0);

    logic [3:0]          offset;
    logic [GPIO_NUM-1:0] wdata;
    logic                wr_dir, wr_out, wr_set, wr_clr;
    logic                wr_ie, wr_rise, wr_fall, wr_pend;

    logic [GPIO_NUM-1:0] dir;
    logic [GPIO_NUM-1:0] out_reg;
    logic [GPIO_NUM-1:0] ie;
    logic [GPIO_NUM-1:0] rise_en;
    logic [GPIO_NUM-1:0] fall_en;
    logic [GPIO_NUM-1:0] pend;

    logic [GPIO_NUM-1:0] sync1_p0;
    logic [GPIO_NUM-1:0] sync2_p1;
    logic [GPIO_NUM-1:0] filt_p2;
    logic [GPIO_NUM-1:0] filt_d_p3;
    logic [GPIO_NUM-1:0] rise_ev;
    logic [GPIO_NUM-1:0] fall_ev;
    logic [GPIO_NUM-1:0] edge_hit;

    // Address bits outside the offset field and data bits above GPIO_NUM are
    // intentionally ignored; collecting them here keeps them visibly unused.
    logic [63:0] unused_bits;
    assign unused_bits = {addr_i, data_i};

    assign offset = addr_i[ADDR_LSB+3:ADDR_LSB];
    assign wdata  = data_i[GPIO_NUM-1:0];

    assign wr_dir  = we_i && (offset == OFF_DIR);
    assign wr_out  = we_i && (offset == OFF_OUT);
    assign wr_set  = we_i && (offset == OFF_SET);
    assign wr_clr  = we_i && (offset == OFF_CLR);
    assign wr_ie   = we_i && (offset == OFF_IE);
    assign wr_rise = we_i && (offset == OFF_RISE);
    assign wr_fall = we_i && (offset == OFF_FALL);
    assign wr_pend = we_i && (offset == OFF_PEND);

    // Plain read/write configuration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir     <= '0;
            ie      <= '0;
            rise_en <= '0;
            fall_en <= '0;
        end else begin
            if (wr_dir)  dir     <= wdata;
            if (wr_ie)   ie      <= wdata;
            if (wr_rise) rise_en <= wdata;
            if (wr_fall) fall_en <= wdata;
        end
    end

    // Output data register with atomic set/clear aliases
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg <= '0;
        end else if (wr_out) begin
            out_reg <= wdata;
        end else if (wr_set) begin
            out_reg <= out_reg | wdata;
        end else if (wr_clr) begin
            out_reg <= out_reg & ~wdata;
        end
    end

    // Two-flop synchroniser for the asynchronous pad inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_p0 <= '0;
            sync2_p1 <= '0;
        end else begin
            sync1_p0 <= io_pin_i;
            sync2_p1 <= sync1_p0;
        end
    end

    generate
        if (FILT_LEN == 0) begin : g_bypass
            assign filt_p2 = sync2_p1;
        end else begin : g_filter
            for (genvar i = 0; i < GPIO_NUM; i++) begin : g_pin
                logic [CNT_W-1:0] cnt;
                logic             val;

                // Accept a new level only after it has differed from the
                // filtered value for FILT_LEN consecutive cycles
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        cnt <= '0;
                        val <= 1'b0;
                    end else if (sync2_p1[i] == val) begin
                        cnt <= '0;
                    end else if (cnt == CNT_MAX) begin
                        val <= sync2_p1[i];
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                assign filt_p2[i] = val;
            end
        end
    endgenerate

    // Delayed copy of the filtered value for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_d_p3 <= '0;
        end else begin
            filt_d_p3 <= filt_p2;
        end
    end

    // Edges are seen regardless of IE and DIR so output loopback is visible
    assign rise_ev  = filt_p2 & ~filt_d_p3;
    assign fall_ev  = ~filt_p2 & filt_d_p3;
    assign edge_hit = (rise_ev & rise_en) | (fall_ev & fall_en);

    // Pending bits: W1C clears, a same-cycle new edge takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~(wr_pend ? wdata : '0)) | edge_hit;
        end
    end

    // Combinational read mux; write-only and unmapped offsets read as zero
    always_comb begin
        data_o = '0;
        case (offset)
            OFF_DIR:  data_o[GPIO_NUM-1:0] = dir;
            OFF_OUT:  data_o[GPIO_NUM-1:0] = out_reg;
            OFF_IN:   data_o[GPIO_NUM-1:0] = filt_p2;
            OFF_IE:   data_o[GPIO_NUM-1:0] = ie;
            OFF_RISE: data_o[GPIO_NUM-1:0] = rise_en;
            OFF_FALL: data_o[GPIO_NUM-1:0] = fall_en;
            OFF_PEND: data_o[GPIO_NUM-1:0] = pend;
            default:  data_o = '0;
        endcase
    end

    assign io_out = out_reg;
    assign io_oe  = dir;
    assign irq_o  = |(pend & ie);

endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: directed checks of gpio_irq, one instance with the default
// 4-cycle filter and one with the filter bypassed.
module tb_gpio_irq;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd, rd0;
    logic [15:0] pins, pins0;
    logic [15:0] io_out, io_oe, out0, oe0;
    logic        irq, irq0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [3:0]  off;
        logic [31:0] wd;
        logic [3:0]  roff;
        logic [31:0] exp_rd;
        logic [15:0] exp_oe;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    gpio_irq #(.GPIO_NUM(16), .FILT_LEN(4), .ADDR_LSB(2)) dut (
        .clk(clk), .rst(rst), .we_i(we), .addr_i(addr), .data_i(wdata),
        .data_o(rd), .io_pin_i(pins), .io_out(io_out), .io_oe(io_oe), .irq_o(irq)
    );

    gpio_irq #(.GPIO_NUM(16), .FILT_LEN(0), .ADDR_LSB(2)) dut0 (
        .clk(clk), .rst(rst), .we_i(we), .addr_i(addr), .data_i(wdata),
        .data_o(rd0), .io_pin_i(pins0), .io_out(out0), .io_oe(oe0), .irq_o(irq0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [31:0] d);
        @(negedge clk);
        we    = 1'b1;
        addr  = {26'b0, off, 2'b00};
        wdata = d;
        @(negedge clk);
        we    = 1'b0;
        wdata = 32'h0;
    endtask

    task automatic rd_chk(input string nm, input logic [3:0] off, input logic [31:0] exp);
        addr = {26'b0, off, 2'b00};
        #1;
        chk(nm, rd, exp);
    endtask

    task automatic rd0_chk(input string nm, input logic [3:0] off, input logic [31:0] exp);
        addr = {26'b0, off, 2'b00};
        #1;
        chk(nm, rd0, exp);
    endtask

    initial begin
        //            we    off   wdata          roff  exp_rd        oe        out
        vecs[0]  = '{1'b1, 4'd0, 32'h0000_00FF, 4'd0, 32'h0000_00FF, 16'h00FF, 16'h0000};
        vecs[1]  = '{1'b1, 4'd1, 32'h0000_A5A5, 4'd1, 32'h0000_A5A5, 16'h00FF, 16'hA5A5};
        vecs[2]  = '{1'b1, 4'd9, 32'h0000_1234, 4'd9, 32'h0000_0000, 16'h00FF, 16'hA5A5};
        vecs[3]  = '{1'b1, 4'd1, 32'h0000_000F, 4'd1, 32'h0000_000F, 16'h00FF, 16'h000F};
        vecs[4]  = '{1'b1, 4'd3, 32'h0000_0100, 4'd1, 32'h0000_010F, 16'h00FF, 16'h010F};
        vecs[5]  = '{1'b1, 4'd4, 32'h0000_0003, 4'd1, 32'h0000_010C, 16'h00FF, 16'h010C};
        vecs[6]  = '{1'b0, 4'd0, 32'h0000_0000, 4'd3, 32'h0000_0000, 16'h00FF, 16'h010C};
        vecs[7]  = '{1'b0, 4'd0, 32'h0000_0000, 4'd4, 32'h0000_0000, 16'h00FF, 16'h010C};
        vecs[8]  = '{1'b1, 4'd5, 32'hFFFF_0008, 4'd5, 32'h0000_0008, 16'h00FF, 16'h010C};
        vecs[9]  = '{1'b1, 4'd6, 32'h0000_0008, 4'd6, 32'h0000_0008, 16'h00FF, 16'h010C};
        vecs[10] = '{1'b1, 4'd7, 32'h0000_0000, 4'd7, 32'h0000_0000, 16'h00FF, 16'h010C};
        vecs[11] = '{1'b0, 4'd0, 32'h0000_0000, 4'd8, 32'h0000_0000, 16'h00FF, 16'h010C};
        vecs[12] = '{1'b1, 4'd2, 32'h0000_FFFF, 4'd2, 32'h0000_0000, 16'h00FF, 16'h010C};
        vecs[13] = '{1'b1, 4'd15, 32'h0000_00FF, 4'd15, 32'h0000_0000, 16'h00FF, 16'h010C};
        vecs[14] = '{1'b1, 4'd0, 32'hFFFF_FFFF, 4'd0, 32'h0000_FFFF, 16'hFFFF, 16'h010C};
        vecs[15] = '{1'b1, 4'd0, 32'h0000_00FF, 4'd0, 32'h0000_00FF, 16'h00FF, 16'h010C};

        rst   = 1'b1;
        we    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        pins  = 16'h0;
        pins0 = 16'h0;

        // Reset state: every register reads zero, pads idle
        repeat (3) @(negedge clk);
        for (int i = 0; i <= 8; i++) rd_chk("reset_read", 4'(i), 32'h0);
        chk("reset_oe", 32'(io_oe), 32'h0);
        chk("reset_out", 32'(io_out), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Register map vectors
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].we) bus_write(vecs[i].off, vecs[i].wd);
            else @(negedge clk);
            rd_chk($sformatf("vec%0d_rd", i), vecs[i].roff, vecs[i].exp_rd);
            chk($sformatf("vec%0d_oe", i), 32'(io_oe), 32'(vecs[i].exp_oe));
            chk($sformatf("vec%0d_out", i), 32'(io_out), 32'(vecs[i].exp_out));
        end

        // 3-cycle glitch on pin3 is rejected by the filter
        @(negedge clk);
        pins[3] = 1'b1;
        repeat (3) @(negedge clk);
        pins[3] = 1'b0;
        repeat (10) @(negedge clk);
        rd_chk("glitch_in", 4'd2, 32'h0);
        rd_chk("glitch_pend", 4'd8, 32'h0);
        chk("glitch_irq", 32'(irq), 32'h0);

        // Held level on pin3: IN after edge k+5, PEND/irq after edge k+6
        @(negedge clk);
        pins[3] = 1'b1;
        repeat (5) @(posedge clk);
        rd_chk("hold_in_k4", 4'd2, 32'h0);
        @(posedge clk);
        rd_chk("hold_in_k5", 4'd2, 32'h8);
        rd_chk("hold_pend_k5", 4'd8, 32'h0);
        chk("hold_irq_k5", 32'(irq), 32'h0);
        @(posedge clk);
        rd_chk("hold_pend_k6", 4'd8, 32'h8);
        chk("hold_irq_k6", 32'(irq), 32'h1);

        // W1C clears pending and irq
        bus_write(4'd8, 32'h8);
        rd_chk("w1c_pend", 4'd8, 32'h0);
        chk("w1c_irq", 32'(irq), 32'h0);

        // Falling edge with FALL=0 leaves PEND clear
        pins[3] = 1'b0;
        repeat (12) @(negedge clk);
        rd_chk("fall_in", 4'd2, 32'h0);
        rd_chk("fall_pend", 4'd8, 32'h0);

        // Edge pends with IE=0; enabling IE then raises irq at once
        bus_write(4'd5, 32'h0);
        pins[3] = 1'b1;
        repeat (12) @(negedge clk);
        rd_chk("noie_pend", 4'd8, 32'h8);
        chk("noie_irq", 32'(irq), 32'h0);
        bus_write(4'd5, 32'h8);
        chk("ie_on_irq", 32'(irq), 32'h1);

        // Asynchronous reset in the middle of a cycle
        bus_write(4'd1, 32'hFF);
        chk("pre_rst_out", 32'(io_out), 32'hFF);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out", 32'(io_out), 32'h0);
        chk("arst_oe", 32'(io_oe), 32'h0);
        chk("arst_irq", 32'(irq), 32'h0);
        rd_chk("arst_pend", 4'd8, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Pin still high emerges as a rising edge, but RISE is now 0
        repeat (12) @(negedge clk);
        rd_chk("post_rst_in", 4'd2, 32'h8);
        rd_chk("post_rst_pend", 4'd8, 32'h0);
        chk("post_rst_irq", 32'(irq), 32'h0);

        // Reprogram: IE/RISE bits 0 and 3, FALL bit 0
        bus_write(4'd5, 32'h9);
        bus_write(4'd6, 32'h9);
        bus_write(4'd7, 32'h1);
        chk("reprog_irq", 32'(irq), 32'h0);
        pins[3] = 1'b0;
        repeat (10) @(negedge clk);
        pins[3] = 1'b1;
        repeat (10) @(negedge clk);
        rd_chk("reprog_pend", 4'd8, 32'h8);
        chk("reprog_irq_hi", 32'(irq), 32'h1);
        bus_write(4'd8, 32'h8);

        // Bypass filter: rising edge on pin0 pends at edge k+2
        @(negedge clk);
        pins0[0] = 1'b1;
        repeat (2) @(posedge clk);
        rd0_chk("byp_rise_k1", 4'd8, 32'h0);
        @(posedge clk);
        rd0_chk("byp_rise_k2", 4'd8, 32'h1);
        chk("byp_rise_irq", 32'(irq0), 32'h1);
        rd0_chk("byp_in", 4'd2, 32'h1);
        bus_write(4'd8, 32'h1);
        rd0_chk("byp_w1c", 4'd8, 32'h0);

        // Bypass filter: falling edge on pin0
        @(negedge clk);
        pins0[0] = 1'b0;
        repeat (2) @(posedge clk);
        rd0_chk("byp_fall_k1", 4'd8, 32'h0);
        @(posedge clk);
        rd0_chk("byp_fall_k2", 4'd8, 32'h1);
        bus_write(4'd8, 32'h1);
        rd0_chk("byp_w1c2", 4'd8, 32'h0);

        // W1C of bit0 in the same cycle as a new edge: set wins
        @(negedge clk);
        pins0[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        we    = 1'b1;
        addr  = {26'b0, 4'd8, 2'b00};
        wdata = 32'h1;
        @(posedge clk);
        #1;
        we    = 1'b0;
        wdata = 32'h0;
        rd0_chk("collide_pend", 4'd8, 32'h1);
        bus_write(4'd8, 32'h1);
        rd0_chk("collide_clear", 4'd8, 32'h0);
        chk("collide_irq", 32'(irq0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
